// File: rtl/addn_pipe_if.sv
// rtl/addn_pipe_if.sv - operand/result handshake bundle for addn_pipe; sub member only with ADDN_PIPE_SUB_EN
interface addn_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
`ifdef ADDN_PIPE_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    // producer/consumer side
    modport master (
`ifdef ADDN_PIPE_SUB_EN
        output sub,
`endif
        output in_valid, a, b, c, out_ready,
        input  in_ready, out_valid, s, co, ovf
    );

    // adder side
    modport slave (
`ifdef ADDN_PIPE_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, c, out_ready,
        output in_ready, out_valid, s, co, ovf
    );
endinterface

// File: rtl/addn_pipe.sv
// rtl/addn_pipe.sv - pipelined WIDTH-bit adder, STAGE_W bits per stage; ADDN_PIPE_SUB_EN enables subtract mode
module addn_pipe #(
    parameter int WIDTH   = 16,
    parameter int STAGE_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    addn_pipe_if.slave io
);
    localparam int STAGES = WIDTH / STAGE_W;
    localparam int LAST   = STAGES - 1;

    logic advance;
    logic msb_cin;
    logic ovf_q;

    // One global enable: the whole pipe holds while the result is blocked.
    assign advance     = ~(io.out_valid & ~io.out_ready);
    assign io.in_ready = advance;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int SW = (k + 1) * STAGE_W;  // sum bits collected after this stage
            localparam int RW = WIDTH - SW;         // operand bits still waiting for later stages

            logic [STAGE_W-1:0] op_a;
            logic [STAGE_W-1:0] op_b;
            logic               cin;
            logic               v_in;
            logic [STAGE_W:0]   add;
            logic [SW-1:0]      s_d;
            logic [SW-1:0]      s_q;
            logic               vld_q;
            logic               cy_q;

            if (k == 0) begin : g_src
                assign op_a = io.a[STAGE_W-1:0];
`ifdef ADDN_PIPE_SUB_EN
                assign op_b = io.b[STAGE_W-1:0] ^ {STAGE_W{io.sub}};
                assign cin  = io.c ^ io.sub;
`else
                assign op_b = io.b[STAGE_W-1:0];
                assign cin  = io.c;
`endif
                assign v_in = io.in_valid;
                assign s_d  = add[STAGE_W-1:0];
            end else begin : g_src
                assign op_a = g_stage[k-1].g_skew.a_q[STAGE_W-1:0];
`ifdef ADDN_PIPE_SUB_EN
                assign op_b = g_stage[k-1].g_skew.b_q[STAGE_W-1:0]
                            ^ {STAGE_W{g_stage[k-1].g_skew.sub_q}};
`else
                assign op_b = g_stage[k-1].g_skew.b_q[STAGE_W-1:0];
`endif
                assign cin  = g_stage[k-1].cy_q;
                assign v_in = g_stage[k-1].vld_q;
                assign s_d  = {add[STAGE_W-1:0], g_stage[k-1].s_q};
            end

            assign add = {1'b0, op_a} + {1'b0, op_b} + {{STAGE_W{1'b0}}, cin};

            // Stage register: valid always tracks the slot, data only loads for valid slots
            // so the outputs stay at their reset value until a real result arrives.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    cy_q  <= 1'b0;
                    s_q   <= '0;
                end else if (advance) begin
                    vld_q <= v_in;
                    if (v_in) begin
                        cy_q <= add[STAGE_W];
                        s_q  <= s_d;
                    end
                end
            end

            if (k < LAST) begin : g_skew
                logic [RW-1:0] a_d;
                logic [RW-1:0] b_d;
                logic [RW-1:0] a_q;
                logic [RW-1:0] b_q;
`ifdef ADDN_PIPE_SUB_EN
                logic          sub_d;
                logic          sub_q;
`endif
                if (k == 0) begin : g_in
                    assign a_d = io.a[WIDTH-1:SW];
                    assign b_d = io.b[WIDTH-1:SW];
`ifdef ADDN_PIPE_SUB_EN
                    assign sub_d = io.sub;
`endif
                end else begin : g_in
                    assign a_d = g_stage[k-1].g_skew.a_q[RW+STAGE_W-1:STAGE_W];
                    assign b_d = g_stage[k-1].g_skew.b_q[RW+STAGE_W-1:STAGE_W];
`ifdef ADDN_PIPE_SUB_EN
                    assign sub_d = g_stage[k-1].g_skew.sub_q;
`endif
                end

                // Skew register: carries the not-yet-added operand chunks with their slot
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
`ifdef ADDN_PIPE_SUB_EN
                        sub_q <= 1'b0;
`endif
                    end else if (advance && v_in) begin
                        a_q <= a_d;
                        b_q <= b_d;
`ifdef ADDN_PIPE_SUB_EN
                        sub_q <= sub_d;
`endif
                    end
                end
            end
        end
    endgenerate

    // Carry into the MSB recovered from the last chunk's sum and operand bits.
    assign msb_cin = g_stage[LAST].add[STAGE_W-1]
                   ^ g_stage[LAST].op_a[STAGE_W-1]
                   ^ g_stage[LAST].op_b[STAGE_W-1];

    // Overflow register, loaded alongside the last stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance && g_stage[LAST].v_in) begin
            ovf_q <= msb_cin ^ g_stage[LAST].add[STAGE_W];
        end
    end

    assign io.out_valid = g_stage[LAST].vld_q;
    assign io.s         = g_stage[LAST].s_q;
    assign io.co        = g_stage[LAST].cy_q;
    assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_addn_pipe.sv
// tb/tb_addn_pipe.sv - directed self-checking bench for addn_pipe (WIDTH=16, STAGE_W=4)
module tb_addn_pipe;
    localparam int WIDTH   = 16;
    localparam int STAGE_W = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t sv[8];

    always #5 clk = ~clk;

    addn_pipe_if #(.WIDTH(WIDTH)) io();

    addn_pipe #(.WIDTH(WIDTH), .STAGE_W(STAGE_W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic c,
                                input logic sub, input logic [15:0] s, input logic co,
                                input logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.sub = sub; v.s = s; v.co = co; v.ovf = ovf;
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic valid);
        io.in_valid = valid;
        io.a        = v.a;
        io.b        = v.b;
        io.c        = v.c;
`ifdef ADDN_PIPE_SUB_EN
        io.sub      = v.sub;
`endif
    endtask

    task automatic check_res(input string tag, input vec_t v);
        check({tag, "_s"},   io.s,   v.s);
        check({tag, "_co"},  io.co,  v.co);
        check({tag, "_ovf"}, io.ovf, v.ovf);
    endtask

    // Called at posedge+1; sends one operand set, measures edges to out_valid.
    task automatic run_one(input string tag, input vec_t v);
        int lat;
        drive(v, 1'b1);
        #1;
        check({tag, "_in_ready"}, io.in_ready, 1);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        lat = 0;
        while (!io.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check_res(tag, v);
        @(posedge clk); #1;
        check({tag, "_single"}, io.out_valid, 0);
    endtask

    initial begin
        int   got, first, last, sent, hold;
        logic seen;
        logic [15:0] held_s;

        sv[0] = mk(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
        sv[1] = mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        sv[2] = mk(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        sv[3] = mk(16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        sv[4] = mk(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        sv[5] = mk(16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0);
        sv[6] = mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        sv[7] = mk(16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0);

        rst = 1'b1;
        drive(sv[0], 1'b0);
        io.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", io.out_valid, 0);
        check("rst_s",         io.s,         0);
        check("rst_co",        io.co,        0);
        check("rst_ovf",       io.ovf,       0);
        check("rst_in_ready",  io.in_ready,  1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_out_valid", io.out_valid, 0);
        check("rel_s",         io.s,         0);
        check("rel_in_ready",  io.in_ready,  1);

        run_one("add_basic",   mk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0));
        run_one("ripple_all",  mk(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0));
        run_one("pos_ovf",     mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
        run_one("neg_ovf",     mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1));

        // back-to-back stream
        got = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 8) drive(sv[cyc], 1'b1);
            else io.in_valid = 1'b0;
            @(posedge clk); #1;
            if (io.out_valid) begin
                if (got < 8) check_res($sformatf("stream%0d", got), sv[got]);
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        check("stream_count", got, 8);
        check("stream_first", first, 3);
        check("stream_span",  last - first, 7);

        // backpressure: three stalled cycles once the first result shows
        got = 0; sent = 0; hold = 0; seen = 1'b0; held_s = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (!seen && io.out_valid) begin
                seen = 1'b1;
                hold = 3;
            end
            io.out_ready = (hold == 0);
            if (sent < 6) drive(sv[sent], 1'b1);
            else io.in_valid = 1'b0;
            #1;
            if (hold > 0) begin
                check("bp_in_ready", io.in_ready, 0);
                check("bp_valid", io.out_valid, 1);
                if (hold == 3) held_s = io.s;
                else check("bp_hold_s", io.s, held_s);
                hold--;
            end
            if (io.out_valid && io.out_ready) begin
                if (got < 6) check_res($sformatf("bp%0d", got), sv[got]);
                got++;
            end
            if (io.in_valid && io.in_ready) sent++;
            @(posedge clk); #1;
        end
        io.out_ready = 1'b1;
        io.in_valid  = 1'b0;
        check("bp_sent",  sent, 6);
        check("bp_count", got,  6);
        check("bp_first_held", held_s, sv[0].s);

        // reset with three operations in flight
        drive(sv[0], 1'b1);
        @(posedge clk); #1;
        drive(sv[1], 1'b1);
        @(posedge clk); #1;
        drive(sv[2], 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        io.in_valid = 1'b0;
        #1;
        check("mid_rst_valid",    io.out_valid, 0);
        check("mid_rst_s",        io.s,         0);
        check("mid_rst_co",       io.co,        0);
        check("mid_rst_ovf",      io.ovf,       0);
        check("mid_rst_in_ready", io.in_ready,  1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("flush_valid", io.out_valid, 0);
            check("flush_s",     io.s,         0);
        end
        run_one("post_rst", sv[5]);

`ifdef ADDN_PIPE_SUB_EN
        run_one("sub_neg", mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0));
        run_one("sub_ovf", mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1));
        run_one("sub_off", mk(16'h0005, 16'h0007, 1'b0, 1'b0, 16'h000C, 1'b0, 1'b0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/addn_pipe.md
# addn_pipe

Parametrised, pipelined N-bit adder with carry-in, carry-out and signed-overflow flag, replacing the fixed 4-bit combinational full adder in the arithmetic library. The operand is split into STAGE_W-bit chunks, one chunk is added per pipeline stage with the carry registered between stages, and transfers use a valid/ready handshake with global stall. It sits between operand producers and accumulators/ALU datapaths that need wide adds at high clock rates.

## Interface
- WIDTH, 16: operand/sum width in bits; must be a multiple of STAGE_W, ≥ STAGE_W.
- STAGE_W, 4: bits added per pipeline stage; STAGES = WIDTH/STAGE_W.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  a, b, c hold a valid operand set.
- in_ready  output  1  block accepts an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  1  carry-in (borrow-in in subtract mode).
- sub  input  1  subtract select; present only with ADDN_PIPE_SUB_EN.
- out_valid  output  1  s, co, ovf hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- s  output  WIDTH  sum.
- co  output  1  carry-out of MSB.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Result: {co, s} = a + b + c, exact (WIDTH+1 bits, no truncation beyond co).
- Stage k (0..STAGES-1) adds chunk k of a and b plus the carry registered from stage k-1 (stage 0 uses c); result chunk and carry register into stage k's output.
- Operand chunks not yet consumed travel forward in skew registers; computed sum chunks travel forward in de-skew registers, so all chunks of one operation emerge together.
- Each stage has a valid bit; out_valid is the last stage's valid bit.
- Global stall: stall = out_valid & ~out_ready. in_ready = ~stall. On stall all pipeline registers (data and valid) hold; otherwise all advance one stage.
- Bubbles: in_valid=0 with in_ready=1 inserts an invalid slot; data registers of invalid slots are don't-care but valid bits must be 0.
- ovf computed in the last stage from the carry into bit WIDTH-1 and co.
- Reset (any time, including mid-operation): all valid bits clear immediately; in-flight operations discarded; s=0, co=0, ovf=0, out_valid=0, in_ready=1 while rst high and after release.

## Timing
- Latency: operand accepted on edge T (in_valid & in_ready) appears with out_valid=1 after edge T+STAGES-1, i.e. STAGES cycles from acceptance to being observable, with no stalls.
- Throughput: one operation per cycle while out_ready=1.
- in_ready is combinational from out_valid (registered) and out_ready; no combinational path from in_valid to out_valid or from a/b to s.
- Result held stable (s, co, ovf, out_valid) for every cycle of a stall.
- STAGES=1 (STAGE_W=WIDTH): latency 1, behaves as a registered adder.
- Critical path: one STAGE_W-bit add plus carry; no path longer than that.

## Configuration
- ADDN_PIPE_SUB_EN defined: sub port exists; sub is captured with the operands and pipelined alongside them. sub=1 computes s = a - b - c as a + ~b + ~c; co=1 means no borrow; ovf is signed subtract overflow. sub=0 identical to plain add.
- Undefined: no sub port, add only; no inversion logic synthesised.

## Test plan
(WIDTH=16, STAGE_W=4, latency 4.)
- Single add: a=16'h1234, b=16'h4321, c=1 accepted at cycle 0 -> cycle 4 out_valid=1, s=16'h5556, co=0, ovf=0.
- Full carry ripple across all stages: a=16'hFFFF, b=16'h0000, c=1 -> s=16'h0000, co=1, ovf=0; a=16'h7FFF, b=1, c=0 -> s=16'h8000, ovf=1, co=0.
- Back-to-back stream of 8 random operand sets with out_ready=1 -> 8 consecutive out_valid cycles, results in order, each equal to a+b+c.
- Backpressure: stream 6 operands, hold out_ready=0 for 3 cycles once out_valid=1 -> in_ready=0 for those cycles, s held constant, no result lost or duplicated.
- Reset mid-flight: accept 3 operands, assert rst for 1 cycle at cycle 2 -> out_valid stays 0, s=0, co=0, ovf=0; next operand after release emerges with latency 4.
- With ADDN_PIPE_SUB_EN: a=16'h0005, b=16'h0007, c=0, sub=1 -> s=16'hFFFE, co=0; a=16'h8000, b=1, c=0, sub=1 -> s=16'h7FFF, ovf=1, co=1.
